pwm_measure: RTL and testbench

//  Measures the high time of a pulse-width-encoded sensor output (ultrasonic ranger, 147 us per inch)
//  and converts it to an 8-bit distance in whole units.

---
 rtl/pwm_measure_pkg.sv | 18 +
 rtl/pwm_measure_sync_edge.sv | 52 +++++
 rtl/pwm_measure.sv | 110 +++++++++++
 tb/tb_pwm_measure.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_measure_pkg.sv
// Package for the pulse-width distance measurement block.
// Holds the measurement FSM state type and the default timing/width
// constants shared by pwm_measure and its synchronizer.
`timescale 1ns/1ps
package pwm_measure_pkg;

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  // 10 MHz system clock, 147 us per distance unit.
  localparam int unsigned DEF_CLK_HZ         = 10_000_000;
  localparam int unsigned DEF_TICKS_PER_UNIT = 1470;
  localparam int unsigned DEF_OUT_W          = 8;
  localparam int unsigned DEF_SYNC_STAGES    = 2;

endpackage

// File: rtl/pwm_measure_sync_edge.sv
// pwm_sync_edge: N-stage synchronizer for an asynchronous pulse input,
// plus single-cycle rise/fall strobes on the synchronized level.
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   din    in   asynchronous input pin
//   level  out  synchronized level (s)
//   rise   out  one-cycle strobe, s & ~s_d
//   fall   out  one-cycle strobe, ~s & s_d
`timescale 1ns/1ps
module pwm_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned FILL   = SYNC_STAGES + 1;
  localparam int unsigned FILL_W = $clog2(FILL + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_d;
  logic [FILL_W-1:0]      fill_cnt;
  logic                   primed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      level_d  <= 1'b0;
      fill_cnt <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
      level_d <= sync_q[SYNC_STAGES-1];
      if (!primed) begin
        fill_cnt <= fill_cnt + FILL_W'(1);
      end
    end
  end

  // Edge strobes stay masked until the synchronizer and the edge history
  // both hold real pin samples; otherwise a pin already high at reset
  // release would look like a fresh rising edge.
  assign primed = (fill_cnt == FILL_W'(FILL));
  assign level  = sync_q[SYNC_STAGES-1];
  assign rise   = primed &  level & ~level_d;
  assign fall   = primed & ~level &  level_d;

endmodule

// File: rtl/pwm_measure.sv
// pwm_measure: measures the high time of a pulse-width-encoded sensor
// output and converts it to a distance in whole units, rounded to nearest.
// distance holds the last completed measurement until the next falling
// edge of the synchronized input.
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset (0 = reset)
//   pwm_in    in   asynchronous pulse input, high time encodes distance
//   distance  out  last measured distance in units, registered
`timescale 1ns/1ps
module pwm_measure
  import pwm_measure_pkg::*;
#(
  parameter int unsigned CLK_HZ         = DEF_CLK_HZ,
  parameter int unsigned TICKS_PER_UNIT = DEF_TICKS_PER_UNIT,
  parameter int unsigned OUT_W          = DEF_OUT_W,
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [OUT_W-1:0] distance
);

  if (CLK_HZ == 0 || TICKS_PER_UNIT < 2 || OUT_W < 1 || SYNC_STAGES < 2) begin : g_bad_params
    $error("pwm_measure: invalid parameter set");
  end

  localparam int unsigned      TICK_W    = $clog2(TICKS_PER_UNIT);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(TICKS_PER_UNIT / 2);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_UNIT - 1);
  localparam logic [OUT_W-1:0]  UNIT_MAX  = '1;

  logic s_level;
  logic s_rise;
  logic s_fall;

  state_t            state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [OUT_W-1:0]  unit_q, unit_d;
  logic [OUT_W-1:0]  dist_q, dist_d;

  pwm_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .din   (pwm_in),
    .level (s_level),
    .rise  (s_rise),
    .fall  (s_fall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      unit_q  <= '0;
      dist_q  <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      unit_q  <= unit_d;
      dist_q  <= dist_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    unit_d  = unit_q;
    dist_d  = dist_q;
    unique case (state_q)
      IDLE: begin
        // Preloading half a unit turns truncation into round-to-nearest.
        if (s_rise) begin
          state_d = MEASURE;
          tick_d  = TICK_HALF;
          unit_d  = '0;
        end
      end
      MEASURE: begin
        if (s_fall) begin
          state_d = IDLE;
          // The rise clock is itself a high clock but the prescaler only
          // advances on the clocks after it; a prescaler sitting on its
          // last tick therefore owes one more unit at capture.
          if (tick_q == TICK_LAST && unit_q != UNIT_MAX) begin
            dist_d = unit_q + OUT_W'(1);
          end else begin
            dist_d = unit_q;
          end
        end else if (s_level) begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (unit_q != UNIT_MAX) begin
              unit_d = unit_q + OUT_W'(1);
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign distance = dist_q;

endmodule

// File: tb/tb_pwm_measure.sv
`timescale 1ns/1ps
module tb_pwm_measure;

  localparam int unsigned TPU_A = 1470;
  localparam int unsigned W_A   = 8;
  localparam int unsigned TPU_B = 6;
  localparam int unsigned W_B   = 4;
  localparam int          GAP   = 200;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           pwm;
  logic [W_A-1:0] dist_a;
  logic [W_B-1:0] dist_b;

  always #50 clk = ~clk;

  pwm_measure #(
    .CLK_HZ         (10_000_000),
    .TICKS_PER_UNIT (TPU_A),
    .OUT_W          (W_A),
    .SYNC_STAGES    (2)
  ) dut_a (
    .clk      (clk),
    .reset    (rst_n),
    .pwm_in   (pwm),
    .distance (dist_a)
  );

  // Small-unit instance so saturation and wrap are reachable in few cycles.
  pwm_measure #(
    .CLK_HZ         (10_000_000),
    .TICKS_PER_UNIT (TPU_B),
    .OUT_W          (W_B),
    .SYNC_STAGES    (2)
  ) dut_b (
    .clk      (clk),
    .reset    (rst_n),
    .pwm_in   (pwm),
    .distance (dist_b)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Behavioural model: expected distance from pulse length by formula.
  int exp_a    = 0;
  int exp_b    = 0;
  int pend_a   = 0;
  int pend_b   = 0;
  int pend_cnt = 0;
  int hi_len   = 0;
  bit armed    = 1'b0;
  bit prev     = 1'b0;
  bit run      = 1'b0;

  int    lit_seq  = 0;
  int    lit_done = 0;
  int    lit_a    = 0;
  int    lit_b    = 0;
  string lit_name = "";

  function automatic int units(int c, int tpu, int maxv);
    int u;
    u = (c + tpu / 2) / tpu;
    return (u > maxv) ? maxv : u;
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      exp_a = 0; exp_b = 0; pend_cnt = 0;
      armed = 1'b0; prev = 1'b0; hi_len = 0;
    end else begin
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          exp_a = pend_a;
          exp_b = pend_b;
        end
      end
      if (pwm) begin
        if (armed) hi_len++;
      end else begin
        // Pin fall seen at this edge: result is visible two edges later.
        if (prev && armed) begin
          pend_a   = units(hi_len, TPU_A, (1 << W_A) - 1);
          pend_b   = units(hi_len, TPU_B, (1 << W_B) - 1);
          pend_cnt = 2;
        end
        armed  = 1'b1;
        hi_len = 0;
      end
      prev = pwm;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  task automatic chk(string nm, int act, int expv);
    total_cnt++;
    if (act == expv) pass_cnt++;
    else $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, expv);
  endtask

  initial forever begin
    @(negedge clk);
    if (run) begin
      chk("dist_a", int'(dist_a), exp_a);
      chk("dist_b", int'(dist_b), exp_b);
      if (lit_seq != lit_done) begin
        lit_done = lit_seq;
        chk({lit_name, "_a"}, int'(dist_a), lit_a);
        chk({lit_name, "_b"}, int'(dist_b), lit_b);
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #20;
  endtask

  task automatic lit(int ea, int eb, string nm);
    lit_a    = ea;
    lit_b    = eb;
    lit_name = nm;
    lit_seq++;
    step(1);
  endtask

  task automatic pulse(int hi, int lo);
    pwm = 1'b1;
    step(hi);
    pwm = 1'b0;
    step(lo);
  endtask

  initial begin
    rst_n = 1'b0;
    pwm   = 1'b0;
    step(1);
    run = 1'b1;
    step(5);
    lit(0, 0, "in_reset");
    step(3);
    rst_n = 1'b1;
    step(10);
    lit(0, 0, "after_reset");

    // Nominal distances
    pulse(1470, GAP); lit(1, 15, "t1_1470");
    pulse(2940, GAP); lit(2, 15, "t2_2940");
    pulse(4410, GAP); lit(3, 15, "t2_4410");
    pulse(5880, GAP); lit(4, 15, "t2_5880");

    // Rounding boundaries
    pulse(734,  GAP); lit(0, 15, "t3_734");
    pulse(735,  GAP); lit(1, 15, "t3_735");
    pulse(2204, GAP); lit(1, 15, "t3_2204");
    pulse(2205, GAP); lit(2, 15, "t3_2205");

    // Short pulses: zero is still an update; small instance boundaries
    pulse(2,  GAP); lit(0, 0,  "short_2");
    pulse(3,  GAP); lit(0, 1,  "short_3");
    pulse(8,  GAP); lit(0, 1,  "short_8");
    pulse(9,  GAP); lit(0, 2,  "short_9");
    pulse(86, GAP); lit(0, 14, "short_86");
    pulse(88, GAP); lit(0, 15, "short_88");

    // Long pulse; small instance saturates without wrapping
    pulse(27210, GAP); lit(19, 15, "t4_long");
    pulse(9, GAP);     lit(0, 2,   "after_sat");

    // Back-to-back: one low clock between pulses
    pulse(1470, 1);
    pulse(2940, GAP); lit(2, 15, "b2b");

    // Reset in the middle of a pulse
    pwm = 1'b1;
    step(2000);
    rst_n = 1'b0;
    lit(0, 0, "t5_async");
    step(4);
    rst_n = 1'b1;
    step(2405);
    pwm = 1'b0;
    step(GAP);
    lit(0, 0, "t5_discard");
    pulse(1470, GAP); lit(1, 15, "t5_next");

    // Input already high at reset release
    rst_n = 1'b0;
    step(2);
    pwm = 1'b1;
    step(10);
    rst_n = 1'b1;
    step(3000);
    pwm = 1'b0;
    step(GAP);
    lit(0, 0, "t6_ignored");
    pulse(2940, GAP); lit(2, 15, "t6_next");

    run = 1'b0;
    step(2);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
